// File: rtl/decade_seq.sv
// Operation sequencer for an external decade timing counter: clears it, paces its
// advance strobes, watches for channel-end/device-end positions and presents status bytes.
module decade_seq #(
    parameter int unsigned ADV_DIV = 2,
    parameter logic [4:0]  CE_POS  = 5'd10,
    parameter logic [4:0]  DE_POS  = 5'd12,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_abort,
    input  logic [4:0] i_dec_count,
    output logic       o_dec_clear,
    output logic       o_dec_advance,
    output logic       o_busy,
    output logic       o_reject,
    output logic [7:0] o_status,
    output logic       o_status_valid,
    input  logic       i_status_ack
);

    localparam int unsigned     TO_W     = $clog2(TIMEOUT + 1);
    localparam logic [3:0]      DIV_LAST = 4'(ADV_DIV - 1);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT - 1);

    localparam logic [7:0] STS_CE    = 8'h08;
    localparam logic [7:0] STS_DE    = 8'h04;
    localparam logic [7:0] STS_CEDE  = 8'h0C;
    localparam logic [7:0] STS_ABORT = 8'h0E;
    localparam logic [7:0] STS_TMO   = 8'h0D;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CLEAR    = 3'd1,
        S_RUN      = 3'd2,
        S_STAT_CE  = 3'd3,
        S_STAT_END = 3'd4
    } state_t;

    state_t          state_r, state_nx_s;
    logic [7:0]      status_r, status_nx_s;
    logic            valid_r, valid_nx_s;
    logic            clear_r, clear_nx_s;
    logic            adv_r, adv_nx_s;
    logic            reject_r, reject_nx_s;
    logic            busy_r, busy_nx_s;
    logic            ce_done_r, ce_done_nx_s;
    logic [3:0]      div_r, div_nx_s;
    logic [TO_W-1:0] to_r, to_nx_s;
    logic            ce_hit_s, de_hit_s;

    assign ce_hit_s = !ce_done_r && (i_dec_count == CE_POS);
    assign de_hit_s = ce_done_r && (i_dec_count == DE_POS);

    // Next-state, next-output and divider/timeout bookkeeping.
    always_comb begin
        state_nx_s   = state_r;
        status_nx_s  = status_r;
        valid_nx_s   = valid_r;
        clear_nx_s   = 1'b0;
        adv_nx_s     = 1'b0;
        ce_done_nx_s = ce_done_r;
        div_nx_s     = div_r;
        to_nx_s      = to_r;

        if ((state_r != S_IDLE) && i_start) begin
            reject_nx_s = 1'b1;
        end else begin
            reject_nx_s = 1'b0;
        end

        case (state_r)
            S_IDLE: begin
                if (i_start) begin
                    state_nx_s   = S_CLEAR;
                    clear_nx_s   = 1'b1;
                    ce_done_nx_s = 1'b0;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_CLEAR: begin
                if (i_abort) begin
                    state_nx_s  = S_STAT_END;
                    status_nx_s = STS_ABORT;
                    valid_nx_s  = 1'b1;
                end else begin
                    state_nx_s = S_RUN;
                    div_nx_s   = 4'd0;
                    to_nx_s    = '0;
                end
            end
            S_RUN: begin
                // The cycle that leaves RUN neither ticks the divider nor pulses advance.
                if (i_abort) begin
                    state_nx_s  = S_STAT_END;
                    status_nx_s = STS_ABORT;
                    valid_nx_s  = 1'b1;
                end else if (ce_hit_s) begin
                    ce_done_nx_s = 1'b1;
                    valid_nx_s   = 1'b1;
                    to_nx_s      = '0;
                    if (CE_POS == DE_POS) begin
                        state_nx_s  = S_STAT_END;
                        status_nx_s = STS_CEDE;
                    end else begin
                        state_nx_s  = S_STAT_CE;
                        status_nx_s = STS_CE;
                    end
                end else if (de_hit_s) begin
                    state_nx_s  = S_STAT_END;
                    status_nx_s = STS_DE;
                    valid_nx_s  = 1'b1;
                    to_nx_s     = '0;
                end else if (to_r == TO_LAST) begin
                    state_nx_s  = S_STAT_END;
                    status_nx_s = STS_TMO;
                    valid_nx_s  = 1'b1;
                end else begin
                    to_nx_s = to_r + 1'b1;
                    if (div_r == DIV_LAST) begin
                        adv_nx_s = 1'b1;
                        div_nx_s = 4'd0;
                    end else begin
                        div_nx_s = div_r + 4'd1;
                    end
                end
            end
            S_STAT_CE: begin
                if (i_abort) begin
                    state_nx_s  = S_STAT_END;
                    status_nx_s = STS_ABORT;
                end else if (i_status_ack) begin
                    state_nx_s  = S_RUN;
                    status_nx_s = 8'h00;
                    valid_nx_s  = 1'b0;
                    to_nx_s     = '0;
                end else begin
                    state_nx_s = S_STAT_CE;
                end
            end
            S_STAT_END: begin
                if (i_status_ack) begin
                    state_nx_s  = S_IDLE;
                    status_nx_s = 8'h00;
                    valid_nx_s  = 1'b0;
                end else begin
                    state_nx_s = S_STAT_END;
                end
            end
            default: begin
                state_nx_s  = S_IDLE;
                status_nx_s = 8'h00;
                valid_nx_s  = 1'b0;
            end
        endcase

        busy_nx_s = (state_nx_s != S_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r   <= S_IDLE;
            status_r  <= 8'h00;
            valid_r   <= 1'b0;
            clear_r   <= 1'b0;
            adv_r     <= 1'b0;
            reject_r  <= 1'b0;
            busy_r    <= 1'b0;
            ce_done_r <= 1'b0;
            div_r     <= 4'd0;
            to_r      <= '0;
        end else begin
            state_r   <= state_nx_s;
            status_r  <= status_nx_s;
            valid_r   <= valid_nx_s;
            clear_r   <= clear_nx_s;
            adv_r     <= adv_nx_s;
            reject_r  <= reject_nx_s;
            busy_r    <= busy_nx_s;
            ce_done_r <= ce_done_nx_s;
            div_r     <= div_nx_s;
            to_r      <= to_nx_s;
        end
    end

    assign o_dec_clear    = clear_r;
    assign o_dec_advance  = adv_r;
    assign o_busy         = busy_r;
    assign o_reject       = reject_r;
    assign o_status       = status_r;
    assign o_status_valid = valid_r;

endmodule

// File: tb/tb_decade_seq.sv
// Bench for decade_seq: two instances (default positions and CE_POS=DE_POS=6) driven by
// shared randomized control inputs and compared every cycle against an operation-level model.
module tb_decade_seq;

    localparam int ADV = 2;
    localparam int TMO = 64;
    localparam int CE_P [2] = '{10, 6};
    localparam int DE_P [2] = '{12, 6};

    localparam int S_IDLE = 0;
    localparam int S_CLR  = 1;
    localparam int S_RUN  = 2;
    localparam int S_SCE  = 3;
    localparam int S_SEND = 4;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       ack;
    logic       freeze;
    logic [4:0] cnt [2];
    logic [1:0] clr, adv, busy, rej, vld;
    logic [7:0] sts [2];

    int n_cmp;
    int n_bad;

    // model: per-instance operation phase, counter value and expected outputs
    int         m_st    [2];
    bit         m_ce    [2];
    int         m_ticks [2];
    int         m_run   [2];
    int         m_cnt   [2];
    bit         e_clr   [2];
    bit         e_adv   [2];
    bit         e_rej   [2];
    bit         e_vld   [2];
    bit         e_busy  [2];
    logic [7:0] e_sts   [2];

    decade_seq u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
        .i_dec_count(cnt[0]), .o_dec_clear(clr[0]), .o_dec_advance(adv[0]),
        .o_busy(busy[0]), .o_reject(rej[0]), .o_status(sts[0]),
        .o_status_valid(vld[0]), .i_status_ack(ack)
    );

    decade_seq #(.CE_POS(5'd6), .DE_POS(5'd6)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
        .i_dec_count(cnt[1]), .o_dec_clear(clr[1]), .o_dec_advance(adv[1]),
        .o_busy(busy[1]), .o_reject(rej[1]), .o_status(sts[1]),
        .o_status_valid(vld[1]), .i_status_ack(ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int d, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s dut%0d t=%0t got %0h expected %0h", tag, d, $time, got, exp);
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            check("clear",   d, {7'd0, clr[d]},  {7'd0, e_clr[d]});
            check("advance", d, {7'd0, adv[d]},  {7'd0, e_adv[d]});
            check("busy",    d, {7'd0, busy[d]}, {7'd0, e_busy[d]});
            check("reject",  d, {7'd0, rej[d]},  {7'd0, e_rej[d]});
            check("valid",   d, {7'd0, vld[d]},  {7'd0, e_vld[d]});
            check("status",  d, sts[d], e_sts[d]);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_st[d] = S_IDLE; m_ce[d] = 1'b0; m_ticks[d] = 0; m_run[d] = 0; m_cnt[d] = 0;
            e_clr[d] = 1'b0; e_adv[d] = 1'b0; e_rej[d] = 1'b0; e_vld[d] = 1'b0;
            e_busy[d] = 1'b0; e_sts[d] = 8'h00;
            cnt[d] = 5'd0;
        end
    endtask

    task automatic finish_op(input int d, input logic [7:0] s);
        m_st[d] = S_SEND; e_vld[d] = 1'b1; e_sts[d] = s;
    endtask

    // One clock of the reference: counter follows the strobes seen this cycle,
    // the operation follows the rules on the count the block sees this cycle.
    task automatic model_edge(input int d);
        int c;
        c = m_cnt[d];
        if (e_clr[d]) m_cnt[d] = 0;
        else if (e_adv[d] && !freeze) m_cnt[d] = (m_cnt[d] + 1) % 32;
        e_rej[d] = (m_st[d] != S_IDLE) && start;
        e_clr[d] = 1'b0;
        e_adv[d] = 1'b0;
        case (m_st[d])
            S_IDLE: if (start) begin m_st[d] = S_CLR; e_clr[d] = 1'b1; m_ce[d] = 1'b0; end
            S_CLR: begin
                if (abort) finish_op(d, 8'h0E);
                else begin m_st[d] = S_RUN; m_ticks[d] = 0; m_run[d] = 0; end
            end
            S_RUN: begin
                if (abort) finish_op(d, 8'h0E);
                else if (!m_ce[d] && c == CE_P[d]) begin
                    m_ce[d] = 1'b1;
                    if (CE_P[d] == DE_P[d]) finish_op(d, 8'h0C);
                    else begin m_st[d] = S_SCE; e_vld[d] = 1'b1; e_sts[d] = 8'h08; end
                end
                else if (m_ce[d] && c == DE_P[d]) finish_op(d, 8'h04);
                else if (m_run[d] + 1 >= TMO) finish_op(d, 8'h0D);
                else begin
                    m_run[d]++;
                    m_ticks[d]++;
                    e_adv[d] = (m_ticks[d] % ADV) == 0;
                end
            end
            S_SCE: begin
                if (abort) finish_op(d, 8'h0E);
                else if (ack) begin m_st[d] = S_RUN; e_vld[d] = 1'b0; e_sts[d] = 8'h00; m_run[d] = 0; end
            end
            S_SEND: if (ack) begin m_st[d] = S_IDLE; e_vld[d] = 1'b0; e_sts[d] = 8'h00; end
            default: ;
        endcase
        e_busy[d] = (m_st[d] != S_IDLE);
    endtask

    task automatic step();
        for (int d = 0; d < 2; d++) model_edge(d);
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) cnt[d] = 5'(m_cnt[d]);
        check_all();
    endtask

    task automatic drain();
        int c;
        c = 0;
        ack = 1'b1; start = 1'b0; abort = 1'b0;
        while (c < 300 && (m_st[0] != S_IDLE || m_st[1] != S_IDLE)) begin
            step();
            c++;
        end
        ack = 1'b0;
        step();
        check("drain_idle", 0, {7'd0, busy[0]}, 8'd0);
        check("drain_idle", 1, {7'd0, busy[1]}, 8'd0);
    endtask

    task automatic do_op(input int lead, input int ce_hold, input int end_hold,
                         input bit poke, input int abort_cnt, input bit noise);
        int hc, he;
        bit poked, done;
        hc = ce_hold; he = end_hold; poked = 1'b0; done = 1'b0;
        abort = 1'b0; ack = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 600 && !done; c++) begin
            ack = 1'b0; abort = 1'b0; start = 1'b0;
            case (m_st[lead])
                S_SCE: if (hc == 0) ack = 1'b1; else hc--;
                S_SEND: if (he == 0) ack = 1'b1; else he--;
                S_RUN: begin
                    if (noise) ack = 1'($urandom_range(0, 1));
                    if (poke && !poked && m_cnt[lead] == 3) begin start = 1'b1; poked = 1'b1; end
                    if (abort_cnt >= 0 && m_cnt[lead] == abort_cnt) abort = 1'b1;
                end
                default: ;
            endcase
            step();
            if (m_st[lead] == S_IDLE) done = 1'b1;
        end
        ack = 1'b0; abort = 1'b0; start = 1'b0;
        check("op_done", lead, {7'd0, done}, 8'd1);
        drain();
    endtask

    initial begin
        int n_to;
        n_cmp = 0; n_bad = 0;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; ack = 1'b0; freeze = 1'b0;
        model_reset();
        #1;
        check_all();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_all();

        // nominal operation, then ack held 20 clocks in STAT_CE
        do_op(0, 0, 0, 1'b0, -1, 1'b0);
        do_op(0, 20, 3, 1'b0, -1, 1'b0);
        // start while busy is rejected
        do_op(0, 1, 1, 1'b1, -1, 1'b0);
        // abort at count 5, and abort coinciding with the CE match
        do_op(0, 0, 2, 1'b0, 5, 1'b0);
        do_op(0, 0, 0, 1'b0, 10, 1'b0);
        // coincident CE/DE instance leads
        do_op(1, 0, 2, 1'b1, -1, 1'b1);

        // frozen counter: timeout after 64 RUN clocks
        freeze = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        n_to = 0;
        while (!vld[0] && n_to < 200) begin step(); n_to++; end
        check("tmo_clocks", 0, 8'(n_to), 8'd65);
        check("tmo_status", 0, sts[0], 8'h0D);
        freeze = 1'b0;
        drain();

        // match on the same clock the timeout would fire: match wins on dut0
        freeze = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 64; k++) step();
        m_cnt[0] = 10;
        cnt[0] = 5'd10;
        step();
        check("tmo_vs_match", 0, sts[0], 8'h08);
        check("tmo_other", 1, sts[1], 8'h0D);
        freeze = 1'b0;
        drain();

        // randomized operations
        for (int i = 0; i < 6; i++) begin
            do_op(0, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 12)) : -1, 1'b1);
        end

        // abort is ignored while idle
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();

        // asynchronous reset while holding in STAT_CE
        start = 1'b1;
        step();
        start = 1'b0;
        n_to = 0;
        while (m_st[0] != S_SCE && n_to < 200) begin step(); n_to++; end
        repeat (3) step();
        check("pre_rst_status", 0, sts[0], 8'h08);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_all();
        do_op(0, 1, 1, 1'b0, -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/decade_seq.md
DECADE_SEQ -- requirements
Module: decade_seq

Interface
REQ-001 The block SHALL have parameter ADV_DIV, default 2, meaning clocks per advance pulse (legal range 1..15).
REQ-002 The block SHALL have parameter CE_POS, default 5'd10, meaning the counter value at which channel end is reported.
REQ-003 The block SHALL have parameter DE_POS, default 5'd12, meaning the counter value at which device end is reported (DE_POS >= CE_POS).
REQ-004 The block SHALL have parameter TIMEOUT, default 64, meaning the maximum clocks in RUN with no compare match.
REQ-005 The block SHALL have port i_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 The block SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port i_start, input, 1 bit: one-cycle operation start request.
REQ-008 The block SHALL have port i_abort, input, 1 bit: halt the operation in progress.
REQ-009 The block SHALL have port i_dec_count, input, 5 bits: current value of the decade timing counter.
REQ-010 The block SHALL have port o_dec_clear, output, 1 bit: clear strobe to the counter.
REQ-011 The block SHALL have port o_dec_advance, output, 1 bit: one-cycle advance strobe to the counter.
REQ-012 The block SHALL have port o_busy, output, 1 bit: high in every state except IDLE.
REQ-013 The block SHALL have port o_reject, output, 1 bit: one-cycle pulse when i_start is refused.
REQ-014 The block SHALL have ports o_status, output, 8 bits, and o_status_valid, output, 1 bit: the status byte (bit7 ATTN, 6 SM, 5 CUE, 4 BUSY, 3 CE, 2 DE, 1 UC, 0 UE) and its valid flag.
REQ-015 The block SHALL have port i_status_ack, input, 1 bit: the channel accepts the status byte.

Function
REQ-016 The FSM SHALL have the states IDLE, CLEAR, RUN, STAT_CE, STAT_END.
REQ-017 IDLE with i_start=1 SHALL go to CLEAR; o_dec_clear SHALL be high for exactly that one CLEAR cycle, then the FSM SHALL enter RUN.
REQ-018 In RUN, o_dec_advance SHALL pulse for one cycle every ADV_DIV clocks; the first pulse SHALL come ADV_DIV clocks after RUN entry.
REQ-019 In RUN, i_dec_count SHALL be compared every cycle; CE_POS matched (CE not yet reported) -> STAT_CE with o_status=0x08.
REQ-020 In RUN after CE has been reported, DE_POS matched -> STAT_END with o_status=0x04.
REQ-021 If CE_POS==DE_POS, a single STAT_END with o_status=0x0C SHALL be produced and STAT_CE skipped.
REQ-022 In STAT_* states, o_status_valid=1, o_status SHALL be held stable, and no advance pulses SHALL be issued; the divider SHALL freeze, not reset.
REQ-023 When i_status_ack=1 while valid: STAT_CE -> RUN, STAT_END -> IDLE; o_status_valid SHALL drop on the next cycle.
REQ-024 i_status_ack with o_status_valid=0 SHALL be ignored.
REQ-025 i_start while o_busy=1 SHALL be ignored except for a one-cycle o_reject pulse; the running operation SHALL be unaffected.
REQ-026 i_abort in CLEAR or RUN -> STAT_END with o_status=0x0E (CE|DE|UC); in STAT_CE -> replace with 0x0E and go to STAT_END; in STAT_END or IDLE it SHALL be ignored.
REQ-027 The RUN timeout counter SHALL reset on RUN entry and on each match; reaching TIMEOUT -> STAT_END with o_status=0x0D (CE|DE|UE).
REQ-028 i_abort and a match in the same cycle: abort SHALL win.
REQ-029 A timeout and a match in the same cycle: the match SHALL win.
REQ-030 o_dec_clear, o_dec_advance, o_reject, o_status_valid and o_busy SHALL all be registered outputs.

Reset
REQ-031 i_rst_n=0 SHALL immediately force IDLE, all outputs to 0, o_status=0x00, and the divider, timeout and CE-reported flag to 0, including mid-operation.
REQ-032 After i_rst_n is released, the first i_start SHALL be honoured on the first rising edge.

Verification
REQ-033 Defaults with the counter modelled as incrementing on advance: i_start -> one clear cycle, advances every 2 clocks, status 0x08 at count 10, ack, status 0x04 at count 12, ack -> IDLE with o_busy=0.
REQ-034 Withhold ack for 20 clocks in STAT_CE -> no o_dec_advance pulses, o_status stays 0x08; after ack, advancing resumes with the divider phase preserved.
REQ-035 i_start pulsed during RUN -> one-cycle o_reject, count sequence unchanged.
REQ-036 i_abort at count 5 -> status 0x0E; ack -> IDLE. In a separate run, freeze the counter -> status 0x0D after 64 RUN clocks.
REQ-037 CE_POS=DE_POS=6 -> a single status 0x0C. Separately, assert i_rst_n low during STAT_CE -> all outputs 0 asynchronously; a fresh i_start then runs normally.
